alu_meta_v2: RTL

Pipelined, parametrised metadata-modification ALU for the RMT action engine; successor to the single-shot 3-cycle metadata ALU. It accepts one {metadata, compare-instruction} word plus action per cycle and applies an opcode-selected field update: destination port, discard flag, next-table id, multicast OR, or saturating counter add. Results drain through an output FIFO with valid/ready backpressure. It sits in each stage's action block, between the lookup/action-RAM output and the stage's metadata output mux.

---
 rtl/alu_meta_v2.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_meta_v2.sv
// rtl/alu_meta_v2.sv - pipelined metadata-modification ALU with credit-gated output FIFO
module alu_meta_v2 #(
    parameter int STAGE       = 0,
    parameter int ACTION_LEN  = 25,
    parameter int META_LEN    = 256,
    parameter int COMP_LEN    = 100,
    parameter int NTID_LSB    = 350,
    parameter int PORT_LSB    = 24,
    parameter int DISCARD_BIT = 128,
    parameter int CNT_LSB     = 224,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [META_LEN+COMP_LEN-1:0] comp_meta_data_in,
    input  logic                         comp_meta_data_valid_in,
    input  logic [ACTION_LEN-1:0]        action_in,
    input  logic                         action_valid_in,
    output logic                         in_ready,
    output logic [META_LEN+COMP_LEN-1:0] comp_meta_data_out,
    output logic                         comp_meta_data_valid_out,
    input  logic                         out_ready,
    output logic [31:0]                  discard_cnt
);
    localparam int W  = META_LEN + COMP_LEN;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 2;

    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic          r_s1_valid;
    logic [W-1:0]  r_s1_data;
    logic [3:0]    r_s1_op;
    logic [7:0]    r_s1_port;
    logic          r_s1_disc;
    logic [5:0]    r_s1_ntid;

    logic          r_s2_valid;
    logic [W-1:0]  r_s2_data;

    logic [W-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_discard_cnt;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_used;
    logic [16:0]   w_cnt_sum;
    logic [W-1:0]  w_result;
    logic          w_unused;

    // Credit covers words already in the pipe, so S2 can never push into a full FIFO.
    assign w_used   = CW'(r_count) + CW'(r_s1_valid) + CW'(r_s2_valid);
    assign in_ready = rst_n && (w_used < CW'(FIFO_DEPTH));
    assign w_accept = comp_meta_data_valid_in && in_ready;

    assign w_push = r_s2_valid;
    assign w_pop  = (r_count != '0) && out_ready;

    assign comp_meta_data_valid_out = (r_count != '0);
    assign comp_meta_data_out       = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign discard_cnt              = r_discard_cnt;

    assign w_unused = ^{action_in[ACTION_LEN-14], action_in[ACTION_LEN-21:0], 1'(STAGE)};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_op    <= '0;
            r_s1_port  <= '0;
            r_s1_disc  <= 1'b0;
            r_s1_ntid  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= comp_meta_data_in;
                r_s1_op   <= action_valid_in ? action_in[ACTION_LEN-1 -: 4] : 4'h0;
                r_s1_port <= action_in[ACTION_LEN-5 -: 8];
                r_s1_disc <= action_in[ACTION_LEN-13];
                r_s1_ntid <= action_in[ACTION_LEN-15 -: 6];
            end
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= w_result;
        end
    end

    always_comb begin
        w_cnt_sum = {1'b0, r_s1_data[CNT_LSB +: 16]} + {9'd0, r_s1_port};
        w_result  = r_s1_data;
        case (r_s1_op)
            4'b1100: begin
                w_result[PORT_LSB +: 8] = r_s1_port;
                w_result[NTID_LSB +: 6] = r_s1_ntid;
            end
            4'b1101: begin
                w_result[DISCARD_BIT]   = r_s1_disc;
                w_result[NTID_LSB +: 6] = r_s1_ntid;
            end
            4'b1110: begin
                w_result[PORT_LSB +: 8] = r_s1_data[PORT_LSB +: 8] | r_s1_port;
                w_result[NTID_LSB +: 6] = r_s1_ntid;
            end
            4'b1111: begin
                w_result[CNT_LSB +: 16] = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
                w_result[NTID_LSB +: 6] = r_s1_ntid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_s2_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_discard_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                if (r_mem[r_rd_ptr][DISCARD_BIT]) begin
                    r_discard_cnt <= r_discard_cnt + 32'd1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule
